// File: rtl/br_pkg.sv
// Shared branch-resolution types: br_op encoding, resolve FSM states and the
// AGEX-to-FE feedback bundle layout {mispred, is_jbr, taken, target, pc, pcplus}.
package br_pkg;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BLT  = 4'd3,
        BGE  = 4'd4,
        BLTU = 4'd5,
        BGEU = 4'd6,
        JAL  = 4'd7,
        JALR = 4'd8
    } br_op_e;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } br_state_e;

    // The three flag bits sit above three DBITS-wide values; FE unpacks in this order.
    localparam int unsigned FB_FLAG_W = 3;

    function automatic int unsigned fb_width(input int unsigned dbits);
        return FB_FLAG_W + 3 * dbits;
    endfunction

endpackage

// File: rtl/br_cond_unit.sv
// Branch condition evaluator: decides taken for an op and its two operands.
module br_cond_unit
    import br_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  br_op_e             op,
    input  logic [DBITS-1:0]   rs1,
    input  logic [DBITS-1:0]   rs2,
    output logic               taken
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        taken = 1'b0;
        unique case (op)
            BEQ:        taken = (rs1 == rs2);
            BNE:        taken = (rs1 != rs2);
            BLT:        taken = ($signed(rs1) <  $signed(rs2));
            BGE:        taken = ($signed(rs1) >= $signed(rs2));
            BLTU:       taken = (rs1 <  rs2);
            BGEU:       taken = (rs1 >= rs2);
            JAL, JALR:  taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/agex_br_resolve.sv
// AGEX branch resolution: computes the real next PC, registers FE feedback and squashes
// wrong-path inputs after a mispredict. Branch statistics are built only with BR_STATS_EN.
module agex_br_resolve
    import br_pkg::*;
#(
    parameter int DBITS       = 32,
    parameter int KILL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [3:0]         in_br_op,
    input  logic [DBITS-1:0]   in_rs1,
    input  logic [DBITS-1:0]   in_rs2,
    input  logic [DBITS-1:0]   in_imm,
    input  logic [DBITS-1:0]   in_pc,
    input  logic [DBITS-1:0]   in_pcplus,
    input  logic [DBITS-1:0]   in_pred_pc,
    output logic               fb_mispred,
    output logic               fb_is_jbr,
    output logic               fb_taken,
    output logic [DBITS-1:0]   fb_target,
    output logic [DBITS-1:0]   fb_pc,
    output logic [DBITS-1:0]   fb_pcplus,
    output logic [DBITS-1:0]   link_val,
    output logic               kill_out,
    output logic [31:0]        stat_total,
    output logic [31:0]        stat_correct
);

    localparam int FB_W  = int'(fb_width(DBITS));
    localparam int CNT_W = $clog2(KILL_CYCLES + 1);

    br_op_e             op;
    logic               taken;
    logic [DBITS-1:0]   br_target;
    logic [DBITS-1:0]   jalr_sum;
    logic [DBITS-1:0]   target;
    logic [DBITS-1:0]   actual_next;
    logic               mispred;
    logic               accept;

    br_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FB_W-1:0]    fb_q, fb_d;

    assign op = br_op_e'(in_br_op);

    br_cond_unit #(.DBITS(DBITS)) u_cond (
        .op    (op),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .taken (taken)
    );

    assign br_target   = in_pc + in_imm;
    assign jalr_sum    = in_rs1 + in_imm;
    assign target      = (op == JALR) ? {jalr_sum[DBITS-1:1], 1'b0} : br_target;
    assign actual_next = taken ? target : in_pcplus;
    assign mispred     = (actual_next != in_pred_pc);
    assign accept      = in_valid && (state_q == RUN) && (op != NONE);

    assign link_val = ((op == JAL) || (op == JALR)) ? in_pcplus : '0;

    // A not-taken mispredict carries PC+4 as its target so FE redirects there.
    assign fb_d = accept ? {mispred, 1'b1, taken, actual_next, in_pc, in_pcplus} : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (accept && mispred) begin
                    cnt_d   = CNT_W'(KILL_CYCLES);
                    state_d = KILL;
                end
            end
            KILL: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fb_q    <= fb_d;
        end
    end

    assign {fb_mispred, fb_is_jbr, fb_taken, fb_target, fb_pc, fb_pcplus} = fb_q;
    assign kill_out = (state_q == KILL);

`ifdef BR_STATS_EN
    logic [31:0] stat_total_q, stat_total_d;
    logic [31:0] stat_correct_q, stat_correct_d;

    assign stat_total_d   = accept ? stat_total_q + 32'd1 : stat_total_q;
    assign stat_correct_d = (accept && !mispred) ? stat_correct_q + 32'd1 : stat_correct_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total_q   <= '0;
            stat_correct_q <= '0;
        end else begin
            stat_total_q   <= stat_total_d;
            stat_correct_q <= stat_correct_d;
        end
    end

    assign stat_total   = stat_total_q;
    assign stat_correct = stat_correct_q;
`else
    assign stat_total   = '0;
    assign stat_correct = '0;
`endif

endmodule

// File: tb/tb_agex_br_resolve.sv
// Scoreboard bench for agex_br_resolve: directed vectors push their hand-computed
// per-cycle expectations; a negedge monitor pops and compares. Honours BR_STATS_EN.
module tb_agex_br_resolve;
    import br_pkg::*;

    localparam int DBITS = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [3:0]         in_br_op;
    logic [DBITS-1:0]   in_rs1, in_rs2, in_imm, in_pc, in_pcplus, in_pred_pc;
    logic               fb_mispred, fb_is_jbr, fb_taken;
    logic [DBITS-1:0]   fb_target, fb_pc, fb_pcplus, link_val;
    logic               kill_out;
    logic [31:0]        stat_total, stat_correct;

    agex_br_resolve #(.DBITS(DBITS), .KILL_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_br_op     (in_br_op),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .in_pc        (in_pc),
        .in_pcplus    (in_pcplus),
        .in_pred_pc   (in_pred_pc),
        .fb_mispred   (fb_mispred),
        .fb_is_jbr    (fb_is_jbr),
        .fb_taken     (fb_taken),
        .fb_target    (fb_target),
        .fb_pc        (fb_pc),
        .fb_pcplus    (fb_pcplus),
        .link_val     (link_val),
        .kill_out     (kill_out),
        .stat_total   (stat_total),
        .stat_correct (stat_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           vld;
        br_op_e         op;
        logic [31:0]    rs1, rs2, imm, pc, pred;
    } stim_t;

    typedef struct {
        logic           mis, jbr, tk;
        logic [31:0]    tgt, pc, pcp;
        logic           kill;
        logic [31:0]    link, tot, cor;
    } exp_t;

    stim_t  stims[$];
    exp_t   exps[$];
    exp_t   sb[$];
    int     nvec  = 0;
    int     nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, nvec, act, exp);
        end
    endtask

    // Stimulus for one cycle plus the outputs expected during that same cycle
    // (fb_* and stats reflect the previous cycle's input, link_val the current one).
    task automatic add(input int rst, input int vld, input br_op_e op,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] pred,
                       input int mis, input int jbr, input int tk,
                       input logic [31:0] tgt, input logic [31:0] fpc, input logic [31:0] fpcp,
                       input int kill, input logic [31:0] link,
                       input logic [31:0] tot, input logic [31:0] cor);
        stim_t s;
        exp_t  e;
        s.rst = (rst != 0); s.vld = (vld != 0); s.op = op;
        s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.pc = pc; s.pred = pred;
        e.mis = (mis != 0); e.jbr = (jbr != 0); e.tk = (tk != 0);
        e.tgt = tgt; e.pc = fpc; e.pcp = fpcp;
        e.kill = (kill != 0); e.link = link;
`ifdef BR_STATS_EN
        e.tot = tot; e.cor = cor;
`else
        e.tot = 32'd0; e.cor = 32'd0;
`endif
        stims.push_back(s);
        exps.push_back(e);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_br_op = 4'd0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_pc = '0; in_pcplus = '0; in_pred_pc = '0;
    endtask

    initial begin
        //   rst vld op    rs1           rs2  imm           pc            pred      | mis jbr tk tgt      fpc           fpcp          kill link   tot cor
        add(0, 1, BEQ,  5,            5,   'h20,         'h100,        'h120,      0, 0, 0, 0,       0,            0,            0, 0,      0, 0);
        add(0, 1, BNE,  5,            5,   'h40,         'h200,        'h240,      0, 1, 1, 'h120,   'h100,        'h104,        0, 0,      1, 1);
        add(0, 1, BEQ,  1,            1,   'h8,          'h300,        'h308,      1, 1, 0, 'h204,   'h200,        'h204,        1, 0,      2, 1);
        add(0, 1, JAL,  0,            0,   'h100,        'h400,        'h0,        0, 0, 0, 0,       0,            0,            1, 'h404,  2, 1);
        add(0, 1, BLT,  'hFFFFFFFF,   1,   'h10,         'h500,        'h510,      0, 0, 0, 0,       0,            0,            0, 0,      2, 1);
        add(0, 1, BLTU, 'hFFFFFFFF,   1,   'h10,         'h600,        'h604,      0, 1, 1, 'h510,   'h500,        'h504,        0, 0,      3, 2);
        add(0, 1, JALR, 'h1001,       0,   'h10,         'h700,        'h1010,     0, 1, 0, 'h604,   'h600,        'h604,        0, 'h704,  4, 3);
        add(0, 1, NONE, 0,            0,   0,            'h800,        0,          0, 1, 1, 'h1010,  'h700,        'h704,        0, 0,      5, 4);
        add(0, 1, BGE,  'hFFFFFFFE,   3,   'h40,         'h900,        'h940,      0, 0, 0, 0,       0,            0,            0, 0,      5, 4);
        add(1, 1, BGEU, 'hFFFFFFFE,   3,   'hFFFFFFF0,   'hA00,        'h9F0,      1, 1, 0, 'h904,   'h900,        'h904,        1, 0,      6, 4);
        add(0, 1, BGEU, 'hFFFFFFFE,   3,   'hFFFFFFF0,   'hA00,        'h9F0,      0, 0, 0, 0,       0,            0,            0, 0,      0, 0);
        add(0, 1, BLTU, 1,            2,   'h20,         'hFFFFFFF0,   'h10,       0, 1, 1, 'h9F0,   'hA00,        'hA04,        0, 0,      1, 1);
        add(0, 1, JAL,  0,            0,   'h80,         'hC00,        'hC80,      0, 1, 1, 'h10,    'hFFFFFFF0,   'hFFFFFFF4,   0, 'hC04,  2, 2);
        add(0, 1, BNE,  3,            4,   'h20,         'hD00,        'hD04,      0, 1, 1, 'hC80,   'hC00,        'hC04,        0, 0,      3, 3);
        add(0, 0, NONE, 0,            0,   0,            0,            0,          1, 1, 1, 'hD20,   'hD00,        'hD04,        1, 0,      4, 3);
        add(0, 0, NONE, 0,            0,   0,            0,            0,          0, 0, 0, 0,       0,            0,            1, 0,      4, 3);
        add(0, 0, BEQ,  1,            1,   4,            'hE00,        0,          0, 0, 0, 0,       0,            0,            0, 0,      4, 3);
        add(0, 0, NONE, 0,            0,   0,            0,            0,          0, 0, 0, 0,       0,            0,            0, 0,      4, 3);

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        foreach (stims[i]) begin
            @(posedge clk);
            #1;
            reset      = stims[i].rst;
            in_valid   = stims[i].vld;
            in_br_op   = stims[i].op;
            in_rs1     = stims[i].rs1;
            in_rs2     = stims[i].rs2;
            in_imm     = stims[i].imm;
            in_pc      = stims[i].pc;
            in_pcplus  = stims[i].pc + 32'd4;
            in_pred_pc = stims[i].pred;
            sb.push_back(exps[i]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("fb_mispred",   32'(fb_mispred),  32'(e.mis));
                check("fb_is_jbr",    32'(fb_is_jbr),   32'(e.jbr));
                check("fb_taken",     32'(fb_taken),    32'(e.tk));
                check("fb_target",    fb_target,        e.tgt);
                check("fb_pc",        fb_pc,            e.pc);
                check("fb_pcplus",    fb_pcplus,        e.pcp);
                check("kill_out",     32'(kill_out),    32'(e.kill));
                check("link_val",     link_val,         e.link);
                check("stat_total",   stat_total,       e.tot);
                check("stat_correct", stat_correct,     e.cor);
                nvec++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors checked", nvec);
        $fatal(1);
    end

endmodule

// File: doc/agex_br_resolve.md
# agex_br_resolve

Branch resolution unit in the AGEX stage and the producer of the AGEX-to-FE feedback bundle that the fetch predictor consumes. It evaluates each conditional branch or jump, computes the real next PC, compares it with the PC that FE predicted, and returns a registered one-cycle feedback pulse. That pulse carries mispredict, is-branch, taken, target, PC and PC+4, and drives BTB/PHT update and redirect. After a mispredict it kills the wrong-path instructions already in flight.

## Interface
- DBITS, 32, data/PC width
- KILL_CYCLES, 2, number of input cycles squashed after a mispredict pulse (1..3)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present at AGEX input this cycle
- in_br_op  in  4  branch op (package encoding; NONE = not a branch)
- in_rs1, in_rs2  in  DBITS each  operand values
- in_imm  in  DBITS  sign-extended immediate
- in_pc, in_pcplus  in  DBITS each  instruction PC and PC+4
- in_pred_pc  in  DBITS  next-PC predicted by FE for this instruction
- fb_mispred, fb_is_jbr, fb_taken  out  1 each  feedback flags, registered
- fb_target, fb_pc, fb_pcplus  out  DBITS each  feedback values, registered
- link_val  out  DBITS  in_pcplus for JAL/JALR, combinational, for writeback
- kill_out  out  1  current AGEX input is squashed; downstream must treat it as a bubble
- stat_total, stat_correct  out  32 each  resolved / correctly predicted branch counts

## Operation
- Branch ops: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned), JAL, JALR.
- Targets:
  - conditional branches and JAL: in_pc + in_imm, modulo 2^DBITS
  - JALR: (in_rs1 + in_imm) with bit 0 cleared
- taken: condition result for conditional branches; always 1 for JAL/JALR.
- actual_next = taken ? target : in_pcplus.
- mispred = (actual_next != in_pred_pc).
- An input is accepted when in_valid = 1, state is RUN, and in_br_op != NONE.
- For an accepted input, the next edge registers the feedback:
  - fb_is_jbr = 1, fb_taken = taken
  - fb_target = actual_next, so a not-taken mispredict redirects to PC+4
  - fb_pc = in_pc, fb_pcplus = in_pcplus, fb_mispred = mispred
- Otherwise all fb_* register to 0. Each pulse lasts exactly one cycle.
- FSM states:
  - RUN: on an accepted input with mispred = 1, load kill counter with KILL_CYCLES and go to KILL.
  - KILL: kill_out = 1. Inputs are ignored regardless of in_valid: no feedback, no stats update. The counter decrements every cycle; when it reaches 0, return to RUN.
- Non-branch valid inputs in RUN pass through with kill_out = 0 and no feedback.
- Back-to-back correctly predicted branches produce a feedback pulse on every cycle.
- A mispredict cannot occur in KILL, because all inputs are suppressed.

## Timing
- Resolve combinationally in cycle N; fb_* are visible in cycle N+1. FE redirects at the end of N+1.
- kill_out is high in cycles N+1 .. N+KILL_CYCLES, combinationally from state.
- link_val has zero latency.
- Reset: state RUN, counter 0, all fb_* 0, kill_out 0, stat_* 0.
- Reset during KILL returns to RUN on that edge, and a pending feedback pulse is dropped.
- Reset has priority over everything else.

## Configuration
- BR_STATS_EN defined:
  - stat_total increments on every accepted branch.
  - stat_correct increments on every accepted branch with mispred = 0.
  - Both are updated on the same edge as the feedback register.
  - Both wrap modulo 2^32.
- BR_STATS_EN undefined: stat_total and stat_correct are tied to 0, and no counter flops exist.

## Structure
- Shared package br_pkg holds:
  - br_op encoding: NONE=0, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
  - FSM state typedef (RUN, KILL)
  - the feedback bundle width and field order {mispred, is_jbr, taken, target, pc, pcplus}, which must match the FE unpack order
- One combinational sub-module, br_cond_unit: takes op, rs1 and rs2, and returns taken.
- Target adders, compare, FSM and stats stay in the top module.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0x120 -> next cycle fb_is_jbr=1, fb_taken=1, fb_target=0x120, fb_mispred=0; kill_out stays 0.
- BNE, rs1=rs2=5, pc=0x200, pred=0x240 (predicted taken) -> fb_taken=0, fb_target=0x204, fb_mispred=1; kill_out=1 for exactly 2 cycles, and valid branches during those cycles produce no feedback.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken.
- JALR, rs1=0x1001, imm=0x10, pred=0x1010 -> fb_target=0x1010, mispred=0; link_val = in_pcplus in the same cycle.
- Apply reset during the cycle after a mispredict -> next cycle kill_out=0, all fb_*=0, stats=0.
- With BR_STATS_EN: send 3 correct branches and 1 mispredicted branch -> stat_total=4, stat_correct=3. Without BR_STATS_EN: both read 0.
